airlock_sequencer: RTL

//  Sequences the airlock chamber between the cabin side (13 PSI, inner door) and the sea side (16000 PSI, outer door).

---
 rtl/airlock_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/airlock_sequencer.sv
// Airlock chamber sequencer: latches cabin/sea door requests, arbitrates them fairly,
// drives the pressurize/vent pumps until the limit flags confirm the target pressure,
// then opens the matching door for a fixed time. Unsafe sensor states latch a fault
// that only reset clears. All outputs are registered decodes of the next state.
module airlock_sequencer #(
  parameter int unsigned DOOR_CYCLES    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TW             = 7
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_in_i,
  input  logic req_out_i,
  input  logic limit_lo_i,
  input  logic limit_hi_i,
  output logic pump_up_o,
  output logic pump_dn_o,
  output logic door_in_o,
  output logic door_out_o,
  output logic busy_o,
  output logic fault_o
);

  typedef enum logic [2:0] {
    StIdle,
    StPress,
    StVent,
    StOpenIn,
    StOpenOut,
    StFault
  } state_e;

  localparam logic [TW-1:0] DoorLast    = TW'(DOOR_CYCLES - 1);
  localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pend_in_q, pend_in_d;
  logic          pend_out_q, pend_out_d;
  logic          last_out_q, last_out_d;  // 1: sea side was served most recently
  logic          serve_in, serve_out;
  logic          pump_up_q, pump_dn_q, door_in_q, door_out_q, busy_q, fault_q;

  // Next-state, timer, pending-request and fairness bookkeeping.
  always_comb begin
    state_d    = state_q;
    timer_d    = '0;
    last_out_d = last_out_q;
    serve_in   = 1'b0;
    serve_out  = 1'b0;
    // A request for the side whose door is already open is discarded.
    pend_in_d  = (state_q == StOpenIn)  ? pend_in_q  : (pend_in_q  | req_in_i);
    pend_out_d = (state_q == StOpenOut) ? pend_out_q : (pend_out_q | req_out_i);

    if (state_q != StFault && limit_lo_i && limit_hi_i) begin
      // Chamber cannot be at both pressures: sensor error.
      state_d = StFault;
    end else begin
      unique case (state_q)
        StIdle: begin
          // When both sides wait, the side not served last goes first.
          serve_in  = pend_in_q & (~pend_out_q | last_out_q);
          serve_out = pend_out_q & (~pend_in_q | ~last_out_q);
          if (serve_in) begin
            state_d = limit_lo_i ? StOpenIn : StVent;
          end else if (serve_out) begin
            state_d = limit_hi_i ? StOpenOut : StPress;
          end
        end
        StVent: begin
          if (limit_lo_i)                  state_d = StOpenIn;
          else if (timer_q == TimeoutLast) state_d = StFault;
          else                             timer_d = timer_q + 1'b1;
        end
        StPress: begin
          if (limit_hi_i)                  state_d = StOpenOut;
          else if (timer_q == TimeoutLast) state_d = StFault;
          else                             timer_d = timer_q + 1'b1;
        end
        StOpenIn: begin
          if (!limit_lo_i)              state_d = StFault;
          else if (timer_q == DoorLast) state_d = StIdle;
          else                          timer_d = timer_q + 1'b1;
        end
        StOpenOut: begin
          if (!limit_hi_i)              state_d = StFault;
          else if (timer_q == DoorLast) state_d = StIdle;
          else                          timer_d = timer_q + 1'b1;
        end
        StFault: state_d = StFault;
        default: state_d = StFault;
      endcase
    end

    if (state_q == StOpenIn && state_d != StOpenIn) begin
      pend_in_d  = 1'b0;
      last_out_d = 1'b0;
    end
    if (state_q == StOpenOut && state_d != StOpenOut) begin
      pend_out_d = 1'b0;
      last_out_d = 1'b1;
    end
  end

  // State, timer and request latches.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      pend_in_q  <= 1'b0;
      pend_out_q <= 1'b0;
      last_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pend_in_q  <= pend_in_d;
      pend_out_q <= pend_out_d;
      last_out_q <= last_out_d;
    end
  end

  // Registered output decode; one-hot per state so doors and pumps never overlap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pump_up_q  <= 1'b0;
      pump_dn_q  <= 1'b0;
      door_in_q  <= 1'b0;
      door_out_q <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      pump_up_q  <= (state_d == StPress);
      pump_dn_q  <= (state_d == StVent);
      door_in_q  <= (state_d == StOpenIn);
      door_out_q <= (state_d == StOpenOut);
      busy_q     <= (state_d != StIdle);
      fault_q    <= (state_d == StFault);
    end
  end

  assign pump_up_o  = pump_up_q;
  assign pump_dn_o  = pump_dn_q;
  assign door_in_o  = door_in_q;
  assign door_out_o = door_out_q;
  assign busy_o     = busy_q;
  assign fault_o    = fault_q;

endmodule
